phy_mem_ctrl_gen: RTL and testbench

// Parametrised physical memory controller between CPU memory stage and board SRAM/serial.

---
 rtl/phy_mem_ctrl_gen.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_phy_mem_ctrl_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mem_ctrl_gen.sv
// Physical memory controller: decodes CPU accesses onto NBANK SRAM banks or a serial port with TX FIFO.
// Optional feature macro: PHY_MEM_BYTE_EN (byte-lane writes via read-modify-write).
module phy_mem_ctrl_gen #(
  parameter int unsigned RAM_AW    = 20,
  parameter int unsigned NBANK     = 2,
  parameter int unsigned RD_WAIT   = 1,
  parameter int unsigned WR_SETUP  = 1,
  parameter int unsigned WR_PULSE  = 1,
  parameter int unsigned WR_HOLD   = 1,
  parameter int unsigned TXQ_DEPTH = 4,
  parameter logic [31:0] COM_BASE  = 32'h1FD003F8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  is_write,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  input  logic [3:0]            byte_en,
  output logic [31:0]           data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_unaligned,
  output logic                  int_com_ack,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [NBANK*32-1:0]   ram_data_o,
  input  logic [NBANK*32-1:0]   ram_data_i,
  output logic [NBANK-1:0]      ram_data_t,
  output logic [NBANK-1:0]      ram_ce_n,
  output logic [NBANK-1:0]      ram_oe_n,
  output logic [NBANK-1:0]      ram_we_n,
  input  logic [7:0]            com_data_in,
  output logic [7:0]            com_data_out,
  output logic                  com_write_en,
  input  logic                  com_read_ready,
  input  logic                  com_write_ready
);

  localparam int unsigned BW   = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int unsigned PW   = $clog2(TXQ_DEPTH);
  localparam int unsigned MAXA = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int unsigned MAXB = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
  localparam int unsigned MAXC = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [32:0] RAM_LIMIT = 33'(NBANK) << (RAM_AW + 2);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SU, WR_PW, WR_HD, DONE, TX_WAIT
`ifdef PHY_MEM_BYTE_EN
    , RMW_RD
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bank_q, bank_d, bank_c;
  logic [RAM_AW-1:0]    ram_addr_q, ram_addr_d;
  logic [31:0]          wdata_q, wdata_d, data_out_q, data_out_d;
  logic                 done_q, done_d, err_q, err_d, ack_q, ack_d, busy_q, busy_d;
  logic [NBANK-1:0]     ce_q, ce_d, oe_q, oe_d, we_q, we_d, t_q, t_d;
  logic [31:0]          rd_bank_c [NBANK];
  logic [31:0]          rdata_c, status_c;
  logic                 is_ram_c, be_push_c;

  logic [7:0]           txq_mem [TXQ_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PW:0]          count_q;
  logic [7:0]           com_data_out_q, push_byte_c;
  logic                 com_write_en_q, full_c, push_c, pop_c;

`ifdef PHY_MEM_BYTE_EN
  logic [3:0]           be_q, be_d;
  assign be_push_c = byte_en[0];
`else
  logic                 unused_byte_en;
  assign unused_byte_en = ^byte_en;
  assign be_push_c      = 1'b1;
`endif

  for (genvar g = 0; g < NBANK; g++) begin : g_rd
    assign rd_bank_c[g] = ram_data_i[g*32 +: 32];
  end

  always_comb begin
    bank_c = '0;
    if (NBANK > 1) bank_c = addr[RAM_AW+2 +: BW];
  end

  assign is_ram_c = {1'b0, addr} < RAM_LIMIT;
  assign rdata_c  = rd_bank_c[bank_q];
  assign full_c   = (count_q == (PW+1)'(TXQ_DEPTH));
  assign status_c = {29'b0, full_c, com_read_ready, ~full_c};
  // A strobe is never issued on two consecutive cycles
  assign pop_c    = (count_q != '0) && com_write_ready && !com_write_en_q;

  // Next-state, datapath and strobe decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    ram_addr_d  = ram_addr_q;
    wdata_d     = wdata_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ack_d       = 1'b0;
    push_c      = 1'b0;
    push_byte_c = data_in[7:0];
`ifdef PHY_MEM_BYTE_EN
    be_d        = be_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (req) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else if (is_ram_c) begin
            bank_d     = bank_c;
            ram_addr_d = addr[RAM_AW+1:2];
            wdata_d    = data_in;
            done_d     = 1'b0;
            if (!is_write) begin
              state_d = RD;
              cnt_d   = CW'(RD_WAIT - 1);
            end else begin
`ifdef PHY_MEM_BYTE_EN
              be_d = byte_en;
              if (byte_en == 4'h0) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else if (byte_en != 4'hF) begin
                state_d = RMW_RD;
                cnt_d   = CW'(RD_WAIT - 1);
              end else begin
                state_d = WR_SU;
                cnt_d   = CW'(WR_SETUP - 1);
              end
`else
              state_d = WR_SU;
              cnt_d   = CW'(WR_SETUP - 1);
`endif
            end
          end else if (addr == COM_BASE) begin
            if (!is_write) begin
              data_out_d = {24'b0, com_data_in};
              ack_d      = 1'b1;
            end else if (be_push_c) begin
              if (!full_c || pop_c) begin
                push_c = 1'b1;
              end else begin
                state_d = TX_WAIT;
                done_d  = 1'b0;
                wdata_d = data_in;
              end
            end
          end else if (addr == COM_BASE + 32'd4) begin
            if (!is_write) data_out_d = status_c;
          end else if (!is_write) begin
            data_out_d = '0;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          data_out_d = rdata_c;
          state_d    = DONE;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef PHY_MEM_BYTE_EN
      RMW_RD: begin
        if (cnt_q == '0) begin
          for (int i = 0; i < 4; i++) begin
            if (!be_q[i]) wdata_d[8*i +: 8] = rdata_c[8*i +: 8];
          end
          state_d = WR_SU;
          cnt_d   = CW'(WR_SETUP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      WR_SU: begin
        if (cnt_q == '0) begin
          state_d = WR_PW;
          cnt_d   = CW'(WR_PULSE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_PW: begin
        if (cnt_q == '0) begin
          state_d = WR_HD;
          cnt_d   = CW'(WR_HOLD - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HD: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_WAIT: begin
        push_byte_c = wdata_q[7:0];
        if (pop_c) begin
          push_c  = 1'b1;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = !(state_d inside {IDLE, DONE});
    ce_d   = '1;
    oe_d   = '1;
    we_d   = '1;
    t_d    = '0;
    case (state_d)
`ifdef PHY_MEM_BYTE_EN
      RMW_RD,
`endif
      RD: begin
        ce_d[bank_d] = 1'b0;
        oe_d[bank_d] = 1'b0;
      end
      WR_SU, WR_HD: begin
        ce_d[bank_d] = 1'b0;
        t_d[bank_d]  = 1'b1;
      end
      WR_PW: begin
        ce_d[bank_d] = 1'b0;
        we_d[bank_d] = 1'b0;
        t_d[bank_d]  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      ram_addr_q <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      ce_q       <= '1;
      oe_q       <= '1;
      we_q       <= '1;
      t_q        <= '0;
`ifdef PHY_MEM_BYTE_EN
      be_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      ce_q       <= ce_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      t_q        <= t_d;
`ifdef PHY_MEM_BYTE_EN
      be_q       <= be_d;
`endif
    end
  end

  // TX FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) txq_mem[wr_ptr_q] <= push_byte_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      com_data_out_q <= '0;
      com_write_en_q <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c) begin
        rd_ptr_q       <= rd_ptr_q + 1'b1;
        com_data_out_q <= txq_mem[rd_ptr_q];
      end
      com_write_en_q <= pop_c;
      count_q        <= count_q + (PW+1)'(push_c) - (PW+1)'(pop_c);
    end
  end

  assign data_out      = data_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_unaligned = err_q;
  assign int_com_ack   = ack_q;
  assign ram_addr      = ram_addr_q;
  assign ram_data_o    = {NBANK{wdata_q}};
  assign ram_data_t    = t_q;
  assign ram_ce_n      = ce_q;
  assign ram_oe_n      = oe_q;
  assign ram_we_n      = we_q;
  assign com_data_out  = com_data_out_q;
  assign com_write_en  = com_write_en_q;

endmodule

// File: tb/tb_phy_mem_ctrl_gen.sv
// Self-checking bench for phy_mem_ctrl_gen: SRAM behavioural model, reference memory and TX byte queue.
module tb_phy_mem_ctrl_gen;

  localparam int unsigned RAM_AW    = 20;
  localparam int unsigned NBANK     = 2;
  localparam int unsigned RD_WAIT   = 2;
  localparam int unsigned WR_SETUP  = 1;
  localparam int unsigned WR_PULSE  = 1;
  localparam int unsigned WR_HOLD   = 1;
  localparam int unsigned TXQ_DEPTH = 4;
  localparam logic [31:0] COM_BASE  = 32'h1FD003F8;
  localparam int RD_LAT = RD_WAIT + 1;
  localparam int WR_LAT = WR_SETUP + WR_PULSE + WR_HOLD + 1;

  logic                clk = 1'b0;
  logic                rst, req, is_write;
  logic [31:0]         addr, data_in, data_out;
  logic [3:0]          byte_en;
  logic                busy, done, err_unaligned, int_com_ack;
  logic [RAM_AW-1:0]   ram_addr;
  logic [NBANK*32-1:0] ram_data_o, ram_data_i;
  logic [NBANK-1:0]    ram_data_t, ram_ce_n, ram_oe_n, ram_we_n;
  logic [7:0]          com_data_in, com_data_out;
  logic                com_write_en, com_read_ready, com_write_ready;

  phy_mem_ctrl_gen #(
    .RAM_AW(RAM_AW), .NBANK(NBANK), .RD_WAIT(RD_WAIT), .WR_SETUP(WR_SETUP),
    .WR_PULSE(WR_PULSE), .WR_HOLD(WR_HOLD), .TXQ_DEPTH(TXQ_DEPTH), .COM_BASE(COM_BASE)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .is_write(is_write), .addr(addr), .data_in(data_in),
    .byte_en(byte_en), .data_out(data_out), .busy(busy), .done(done),
    .err_unaligned(err_unaligned), .int_com_ack(int_com_ack), .ram_addr(ram_addr),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_data_t(ram_data_t),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .com_data_in(com_data_in), .com_data_out(com_data_out), .com_write_en(com_write_en),
    .com_read_ready(com_read_ready), .com_write_ready(com_write_ready)
  );

  always #5 clk = ~clk;

  // Board SRAM: write on a clock edge while ce/we low, read whenever ce/oe low
  logic [31:0] sram [NBANK][64];
  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NBANK; b++)
        for (int w = 0; w < 64; w++) sram[b][w] <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++)
        if (!ram_ce_n[b] && !ram_we_n[b] && ram_data_t[b])
          sram[b][ram_addr[5:0]] <= ram_data_o[b*32 +: 32];
    end
  end

  always_comb begin
    ram_data_i = '0;
    for (int b = 0; b < NBANK; b++)
      ram_data_i[b*32 +: 32] = (!ram_ce_n[b] && !ram_oe_n[b]) ? sram[b][ram_addr[5:0]] : 32'hBAD0_BAD0;
  end

  // Bus monitor: strobe activity per bank and transmitted bytes
  int              cyc = 0;
  int              we_cnt [NBANK];
  int              ce_cnt [NBANK];
  logic [RAM_AW-1:0] we_addr = '0;
  logic [7:0]      tx_log [$];
  int              last_tx = -10;
  int              tx_gap_bad = 0;
  initial for (int b = 0; b < NBANK; b++) begin we_cnt[b] = 0; ce_cnt[b] = 0; end
  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int b = 0; b < NBANK; b++) begin
      if (!ram_we_n[b]) we_cnt[b] = we_cnt[b] + 1;
      if (!ram_ce_n[b]) ce_cnt[b] = ce_cnt[b] + 1;
    end
    if (ram_we_n != '1) we_addr = ram_addr;
    if (com_write_en) begin
      if (cyc - last_tx < 2) tx_gap_bad = tx_gap_bad + 1;
      last_tx = cyc;
      tx_log.push_back(com_data_out);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic err, output logic ack);
    @(negedge clk);
    req = 1'b1; is_write = wr; addr = a; data_in = d;
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    err = err_unaligned;
    ack = int_com_ack;
  endtask

  function automatic logic [31:0] ram_a(input int bk, input int wd);
    return (32'(bk) << (RAM_AW + 2)) | (32'(wd) << 2);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] ref_mem [NBANK][64];
  logic [31:0] exp_dout;
  logic [7:0]  exp_tx [$];

  initial begin
    int lat, snap0, snap1, stall_bad, ntx;
    logic err, ack;
    for (int b = 0; b < NBANK; b++)
      for (int w = 0; w < 64; w++) ref_mem[b][w] = '0;
    exp_dout = '0;
    rst = 1'b1; req = 1'b0; is_write = 1'b0; addr = '0; data_in = '0; byte_en = 4'hF;
    com_data_in = '0; com_read_ready = 1'b0; com_write_ready = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    chk("rst_ce", 32'(ram_ce_n), 32'h3);
    chk("rst_we", 32'(ram_we_n), 32'h3);
    chk("rst_oe", 32'(ram_oe_n), 32'h3);
    chk("rst_t", 32'(ram_data_t), 32'h0);
    chk("rst_txen", 32'(com_write_en), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Write then read back a word in bank 0
    snap0 = we_cnt[0];
    access(1'b1, 32'h0000_0010, 32'hDEADBEEF, lat, err, ack);
    ref_mem[0][4] = 32'hDEADBEEF;
    chk("t1_wr_lat", lat, WR_LAT);
    chk("t1_we_cycles", we_cnt[0] - snap0, WR_PULSE);
    access(1'b0, 32'h0000_0010, 32'h0, lat, err, ack);
    exp_dout = ref_mem[0][4];
    chk("t1_rd_lat", lat, RD_LAT);
    chk("t1_rd_data", data_out, exp_dout);

    // Bank 1 select
    snap0 = ce_cnt[0]; snap1 = we_cnt[1];
    access(1'b1, 32'h0040_0000, 32'h1234_5678, lat, err, ack);
    ref_mem[1][0] = 32'h1234_5678;
    chk("t2_bank0_ce", ce_cnt[0] - snap0, 0);
    chk("t2_bank1_we", we_cnt[1] - snap1, WR_PULSE);
    chk("t2_ram_addr", 32'(we_addr), 32'd0);
    access(1'b0, 32'h0040_0000, 32'h0, lat, err, ack);
    exp_dout = ref_mem[1][0];
    chk("t2_rd_data", data_out, exp_dout);

    // Unaligned read leaves data_out alone and touches no bank
    snap0 = ce_cnt[0] + ce_cnt[1];
    access(1'b0, 32'h0000_0003, 32'h0, lat, err, ack);
    chk("t4_lat", lat, 1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_dout", data_out, exp_dout);
    chk("t4_no_strobe", ce_cnt[0] + ce_cnt[1] - snap0, 0);

    // Unmapped read returns zero
    access(1'b0, 32'h1000_0000, 32'h0, lat, err, ack);
    exp_dout = '0;
    chk("unmap_dout", data_out, exp_dout);
    chk("unmap_err", 32'(err), 32'd0);
    chk("unmap_lat", lat, 1);

    // Randomized mix against the reference memory
    for (int it = 0; it < 40; it++) begin
      int op, bk, wd;
      logic [31:0] d;
      op = $urandom_range(0, 3);
      bk = $urandom_range(0, NBANK - 1);
      wd = $urandom_range(0, 63);
      d  = $urandom;
      case (op)
        0: begin
          access(1'b1, ram_a(bk, wd), d, lat, err, ack);
          ref_mem[bk][wd] = d;
          chk("rnd_wr_lat", lat, WR_LAT);
        end
        1: begin
          access(1'b0, ram_a(bk, wd), 32'h0, lat, err, ack);
          exp_dout = ref_mem[bk][wd];
          chk("rnd_rd_lat", lat, RD_LAT);
          chk("rnd_rd_data", data_out, exp_dout);
        end
        2: begin
          com_data_in = d[7:0];
          access(1'b0, COM_BASE, 32'h0, lat, err, ack);
          exp_dout = {24'b0, d[7:0]};
          chk("rnd_com_data", data_out, exp_dout);
          chk("rnd_com_ack", 32'(ack), 32'd1);
        end
        default: begin
          access(d[31], ram_a(bk, wd) | 32'($urandom_range(1, 3)), d, lat, err, ack);
          chk("rnd_unal_err", 32'(err), 32'd1);
          chk("rnd_unal_lat", lat, 1);
          chk("rnd_unal_dout", data_out, exp_dout);
        end
      endcase
    end

    // Status register with empty FIFO
    com_read_ready = 1'b1;
    access(1'b0, COM_BASE + 32'd4, 32'h0, lat, err, ack);
    chk("stat_empty_rr", data_out, 32'h3);
    com_read_ready = 1'b0;
    access(1'b0, COM_BASE + 32'd4, 32'h0, lat, err, ack);
    chk("stat_empty", data_out, 32'h1);

    // Fill the TX FIFO while the transmitter is busy
    for (int i = 0; i < TXQ_DEPTH; i++) begin
      logic [31:0] d;
      d = $urandom;
      access(1'b1, COM_BASE, d, lat, err, ack);
      exp_tx.push_back(d[7:0]);
      chk("tx_push_lat", lat, 1);
    end
    access(1'b0, COM_BASE + 32'd4, 32'h0, lat, err, ack);
    chk("stat_full", data_out, 32'h4);
    begin
      logic [31:0] d;
      d = $urandom;
      exp_tx.push_back(d[7:0]);
      @(negedge clk);
      req = 1'b1; is_write = 1'b1; addr = COM_BASE; data_in = d;
      @(negedge clk);
      req = 1'b0;
    end
    stall_bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) stall_bad++;
      @(negedge clk);
    end
    chk("tx_full_stall", stall_bad, 0);
    com_write_ready = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 20);
    chk("tx_unstall_lat", lat, 1);
    repeat (20) @(negedge clk);
    chk("tx_count", tx_log.size(), exp_tx.size());
    ntx = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
    for (int i = 0; i < ntx; i++) chk("tx_byte", 32'(tx_log[i]), 32'(exp_tx[i]));
    chk("tx_gap", tx_gap_bad, 0);

    // Partial-lane write
    access(1'b1, 32'h0000_0020, 32'h1122_3344, lat, err, ack);
    byte_en = 4'b0010;
    access(1'b1, 32'h0000_0020, 32'hAABB_CCDD, lat, err, ack);
`ifdef PHY_MEM_BYTE_EN
    chk("be_wr_lat", lat, RD_WAIT + WR_LAT);
    exp_dout = 32'h1122_CC44;
`else
    chk("be_wr_lat", lat, WR_LAT);
    exp_dout = 32'hAABB_CCDD;
`endif
    byte_en = 4'hF;
    access(1'b0, 32'h0000_0020, 32'h0, lat, err, ack);
    chk("be_rd_data", data_out, exp_dout);

    // Reset in the middle of a write pulse with bytes queued
    com_write_ready = 1'b0;
    access(1'b1, COM_BASE, 32'h55, lat, err, ack);
    access(1'b1, COM_BASE, 32'h66, lat, err, ack);
    @(negedge clk);
    req = 1'b1; is_write = 1'b1; addr = 32'h0000_0030; data_in = 32'hCAFE_F00D;
    @(negedge clk);
    req = 1'b0;
    lat = 0;
    while (ram_we_n === 2'b11 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rstw_reached_pw", 32'(ram_we_n), 32'h2);
    rst = 1'b1;
    #1;
    chk("rstw_we", 32'(ram_we_n), 32'h3);
    chk("rstw_ce", 32'(ram_ce_n), 32'h3);
    chk("rstw_busy", 32'(busy), 32'd0);
    chk("rstw_t", 32'(ram_data_t), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    com_write_ready = 1'b1;
    ntx = tx_log.size();
    repeat (10) @(negedge clk);
    chk("rstw_fifo_empty", tx_log.size() - ntx, 0);
    access(1'b0, COM_BASE + 32'd4, 32'h0, lat, err, ack);
    chk("rstw_status", data_out, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
